// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice per clock, LSB first.
// A three-state IDLE/RUN/DONE controller produces registered busy/done/S/Cout.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             last_d;
  logic             sum_lsb_unused;

  // One bit-slice of the addition and the last-slice detect
  always_comb begin
    sum_d   = {fa_sum(a_q[0], b_q[0], carry_q), sum_q[WIDTH-1:1]};
    carry_d = fa_carry(a_q[0], b_q[0], carry_q);
    if (cnt_q == CW'(WIDTH - 1)) begin
      last_d = 1'b1;
    end else begin
      last_d = 1'b0;
    end
  end

  // The oldest sum bit is shifted out and replaced; S captures sum_d directly
  assign sum_lsb_unused = sum_q[0];

  // Controller, datapath shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            s_q     <= sum_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle model for WIDTH=8 plus directed
// vectors, continuous random operation, and an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [W-1:0] S;
  logic         Cout;

  logic         start4;
  logic [3:0]   a4, b4;
  logic         cin4;
  logic         busy4, done4;
  logic [3:0]   s4;
  logic         cout4;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing model: an accepted op is busy for W cycles, then done for one,
  // and the adder is free again W+2 edges after acceptance.
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_acc = 0;
  logic [W:0] m_pend;
  logic [W-1:0] m_S;
  logic       m_Cout;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0;
      m_S      <= '0;
      m_Cout   <= 1'b0;
    end else begin
      if (m_active && (cyc - m_acc == W)) begin
        m_S    <= m_pend[W-1:0];
        m_Cout <= m_pend[W];
      end
      if (start && (!m_active || (cyc - m_acc >= W + 2))) begin
        m_active <= 1'b1;
        m_acc    <= cyc;
        m_pend   <= {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
      end
    end
  end

  always @(negedge clk) begin : cmp
    int  d;
    bit  e_busy, e_done;
    if (chk_en) begin
      d      = (cyc - 1) - m_acc;
      e_busy = m_active && (d >= 0) && (d <= W - 1);
      e_done = m_active && (d == W);
      chk("model_busy", 32'(busy), 32'(e_busy));
      chk("model_done", 32'(done), 32'(e_done));
      chk("model_S",    32'(S),    32'(m_S));
      chk("model_Cout", 32'(Cout), 32'(m_Cout));
    end
  end

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done8_timeout: got no done after %0d cycles, required a pulse", n);
    end
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done4 && n < 40);
    if (!done4) begin
      n_chk++;
      n_fail++;
      $display("FAIL done4_timeout: got no done after %0d cycles, required a pulse", n);
    end
  endtask

  // Caller is at a negedge; issues one op and checks latency and result.
  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic ec);
    int n;
    A = a; B = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_done8(n);
    chk({name, "_latency"}, 32'(n), 32'd8);
    chk({name, "_S"}, 32'(S), 32'(es));
    chk({name, "_Cout"}, 32'(Cout), 32'(ec));
  endtask

  initial begin : stim
    int n, ndone;
    logic [7:0] s_seen;
    logic       c_seen;
    logic [8:0] expq[$];
    logic [8:0] e;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S",    32'(S),    32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);

    // start accepted on the very first edge out of reset
    rst_n = 1'b1;
    op8("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    @(negedge clk);
    op8("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    op8("fullrange", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    op8("mixed", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // start re-pulsed and operands zeroed mid-RUN must be ignored
    @(negedge clk);
    A = 8'h12; B = 8'h34; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 8'h00; B = 8'h00; Cin = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    ndone = 0; s_seen = '0; c_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        s_seen = S;
        c_seen = Cout;
      end
    end
    chk("ignore_ndone", 32'(ndone), 32'd1);
    chk("ignore_S", 32'(s_seen), 32'h47);
    chk("ignore_Cout", 32'(c_seen), 32'd0);

    // reset on the 4th RUN edge discards the operation
    A = 8'h55; B = 8'h11; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_S",    32'(S),    32'd0);
    chk("midrst_Cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);

    // continuous start with 100 random triples
    A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255)); Cin = 1'($urandom_range(0, 1));
    expq.push_back({1'b0, A} + {1'b0, B} + {8'd0, Cin});
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wait_done8(n);
      chk("cont_spacing", 32'(n), (i == 0) ? 32'd9 : 32'd10);
      e = expq.pop_front();
      chk("cont_result", 32'({Cout, S}), 32'(e));
      if (i < 99) begin
        A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255)); Cin = 1'($urandom_range(0, 1));
        expq.push_back({1'b0, A} + {1'b0, B} + {8'd0, Cin});
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // exhaustive WIDTH=4 sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          wait_done4(n);
          chk("sweep4", 32'({cout4, s4}), 32'(a + b + c));
          @(negedge clk);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to add; sampled on a rising edge only while the block is IDLE.
REQ-005 A  input  WIDTH  augend; sampled only on the edge that accepts start.
REQ-006 B  input  WIDTH  addend; sampled only on the edge that accepts start.
REQ-007 Cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while the operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse marking S and Cout as newly valid.
REQ-010 S  output  WIDTH  registered sum.
REQ-011 Cout  output  1  registered carry-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE SHALL go to RUN on an edge where start=1, and otherwise remain in IDLE.
REQ-014 RUN SHALL go to DONE after exactly WIDTH RUN edges.
REQ-015 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-016 On the accept edge, the block SHALL load A and B into internal right-shift registers, load Cin into the carry flop, and clear the bit counter to 0.
REQ-017 On each RUN edge, the block SHALL compute one bit-slice with full-adder logic: sum = a0 ^ b0 ^ c, and carry = majority(a0, b0, c).
REQ-018 On each RUN edge, the sum bit SHALL shift into the MSB of the internal sum register, both operand registers SHALL shift right by one, the carry flop SHALL take the new carry, and the counter SHALL increment.
REQ-019 Bit order SHALL be LSB first, so that after WIDTH slices the internal sum register holds (A + B + Cin) mod 2^WIDTH.
REQ-020 On the edge that enters DONE, S SHALL load the internal sum register and Cout SHALL load the carry flop.
REQ-021 S and Cout SHALL change on no other edge, except reset, and SHALL hold their value through IDLE and RUN.
REQ-022 busy SHALL be 1 exactly in RUN.
REQ-023 done SHALL be 1 exactly in DONE, which lasts one cycle.
REQ-024 Latency SHALL be fixed: if start is accepted at edge t, done is high in the cycle after edge t+WIDTH and is low again after edge t+WIDTH+1.
REQ-025 start asserted during RUN or DONE SHALL be ignored, and SHALL NOT be queued.
REQ-026 A, B and Cin changing during RUN SHALL NOT affect the result in progress.
REQ-027 Back-to-back operation: holding start=1 continuously SHALL yield one accepted operation every WIDTH+2 cycles.
REQ-028 The counter width SHALL be clog2(WIDTH+1), and the counter SHALL NOT wrap within an operation.
REQ-029 Full-range arithmetic is required: A = B = 2^WIDTH-1 with Cin=1 SHALL give S = 2^WIDTH-1 and Cout=1.

Reset
REQ-030 On any edge with rst_n=0, the block SHALL enter IDLE and clear busy, done, S, Cout, the counter, the carry flop and all shift registers to 0.
REQ-031 Reset SHALL take priority over start and over every state transition.
REQ-032 Reset asserted mid-RUN SHALL discard the partial result, SHALL produce no done pulse, and SHALL leave S and Cout at 0.
REQ-033 On the first edge with rst_n=1, start=1 SHALL be accepted normally.

Verification
REQ-034 Basic add (WIDTH=8): A=8'h35, B=8'h4A, Cin=0, start pulsed at edge t -> busy high for 8 cycles, done high only after edge t+8, S=8'h7F, Cout=0.
REQ-035 Carry-out (WIDTH=8): A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1; then A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
REQ-036 Ignored start and operand isolation: start re-pulsed and A/B changed to 8'h00 during RUN -> the result is still the first operation's, and only one done pulse appears.
REQ-037 Reset mid-operation: rst_n=0 at the 4th RUN edge -> the next cycle shows busy=0, done=0, S=0, Cout=0, and no done pulse ever follows.
REQ-038 Continuous start with 100 random (A, B, Cin) triples -> each S/Cout equals the golden A+B+Cin, done pulses are spaced exactly 10 cycles apart, and S is stable between pulses.
REQ-039 Exhaustive sweep (WIDTH=4): all 512 (A, B, Cin) combinations -> {Cout, S} == A+B+Cin for every combination.
